uart_tx_frame_engine: RTL and testbench

- Parametrised successor to the single-frame UART transmitter.
- Serialises one character per valid/ready handshake into a start/data/parity/stop frame on TX, timed by an oversampling tick input.
- Frame format (5..MAX_DATA_W data bits, parity mode, 1/2 stop bits) is a per-character runtime configuration, latched at acceptance.
- Sits between the transmit holding register/status logic and the TX pad, clocked by the generated baud-domain clock.

---
 rtl/uart_tx_frame_engine.sv | 157 +++++++++++++++
 tb/tb_uart_tx_frame_engine.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame_engine.sv
// UART transmit frame engine: start/data/parity/stop serialiser with a per-character frame format.
// Optional feature macro UART_TX_BREAK_EN adds break_req, which holds TX low between frames.
module uart_tx_frame_engine #(
  parameter int MAX_DATA_W = 9,
  parameter int OVERSAMPLE = 16,
  parameter int CNT_W      = 6
) (
  input  logic                  the_new_generated_clock,
  input  logic                  reset,
  input  logic                  sample_tick,
  input  logic [MAX_DATA_W-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic [3:0]            cfg_data_bits,
  input  logic                  cfg_parity_en,
  input  logic                  cfg_parity_odd,
  input  logic                  cfg_two_stop,
`ifdef UART_TX_BREAK_EN
  input  logic                  break_req,
`endif
  output logic                  TX,
  output logic                  tx_busy,
  output logic                  tx_done
);

  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(OVERSAMPLE - 1);
  localparam logic [3:0]       MAX_BITS  = 4'(MAX_DATA_W);

`ifdef UART_TX_BREAK_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK, BREAK_HOLD} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`endif

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [3:0]            idx_q, idx_d;
  logic [3:0]            nbits_q, nbits_in;
  logic [MAX_DATA_W-1:0] data_q, data_in;
  logic                  parity_q, parity_in;
  logic                  parity_en_q, two_stop_q;
  logic                  stop2_q, stop2_d;
  logic                  load, counting, bit_end, tx_d;

  // Clamp the width and mask unused bits so parity only covers bits actually sent.
  always_comb begin : cfg_decode
    nbits_in = cfg_data_bits;
    if (cfg_data_bits < 4'd5)          nbits_in = 4'd5;
    else if (cfg_data_bits > MAX_BITS) nbits_in = MAX_BITS;
    data_in   = '0;
    parity_in = cfg_parity_odd;
    for (int i = 0; i < MAX_DATA_W; i++) begin
      data_in[i] = tx_data[i] && (i < int'(nbits_in));
      parity_in  = parity_in ^ data_in[i];
    end
  end

  always_comb begin : tick_gate
    counting = (state_q != IDLE);
`ifdef UART_TX_BREAK_EN
    if (state_q == BREAK) counting = 1'b0;
`endif
  end

  assign bit_end = counting && sample_tick && (cnt_q == LAST_TICK);

  always_comb begin : next_state
    // NOTE: every signal gets a default up front so no path through the case infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    stop2_d = stop2_q;
    load    = 1'b0;
    if (counting && sample_tick) cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    case (state_q)
      IDLE: begin
        if (tx_valid && tx_ready) begin
          load    = 1'b1;
          state_d = START;
          cnt_d   = '0;
          stop2_d = 1'b0;
        end
`ifdef UART_TX_BREAK_EN
        else if (break_req) state_d = BREAK;
`endif
      end
      START: if (bit_end) begin
        state_d = DATA;
        idx_d   = '0;
      end
      DATA: if (bit_end) begin
        if (idx_q == nbits_q - 4'd1) state_d = parity_en_q ? PARITY : STOP;
        else                         idx_d   = idx_q + 4'd1;
      end
      PARITY: if (bit_end) state_d = STOP;
      STOP: if (bit_end) begin
        if (two_stop_q && !stop2_q) stop2_d = 1'b1;
        else                        state_d = IDLE;
      end
`ifdef UART_TX_BREAK_EN
      BREAK:      if (!break_req) state_d = BREAK_HOLD;
      BREAK_HOLD: if (bit_end)    state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Line level is decoded from the next state so TX changes in the same edge as the state.
  always_comb begin : line_decode
    tx_d = 1'b1;
    case (state_d)
      START:  tx_d = 1'b0;
      DATA:   tx_d = data_q[idx_d];
      PARITY: tx_d = parity_q;
`ifdef UART_TX_BREAK_EN
      BREAK:  tx_d = 1'b0;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge the_new_generated_clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      stop2_q     <= 1'b0;
      nbits_q     <= '0;
      data_q      <= '0;
      parity_q    <= 1'b0;
      parity_en_q <= 1'b0;
      two_stop_q  <= 1'b0;
      TX          <= 1'b1;
      tx_busy     <= 1'b0;
      tx_done     <= 1'b0;
      tx_ready    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      stop2_q <= stop2_d;
      if (load) begin
        data_q      <= data_in;
        nbits_q     <= nbits_in;
        parity_q    <= parity_in;
        parity_en_q <= cfg_parity_en;
        two_stop_q  <= cfg_two_stop;
      end
      TX       <= tx_d;
      tx_busy  <= (state_d inside {START, DATA, PARITY, STOP});
      tx_done  <= (state_q == STOP) && (state_d == IDLE);
      tx_ready <= (state_d == IDLE);
    end
  end

endmodule

// File: tb/tb_uart_tx_frame_engine.sv
// Self-checking bench for uart_tx_frame_engine: randomized frames against a tick-level line model.
// Define UART_TX_BREAK_EN for both files to also exercise the break feature.
module tb_uart_tx_frame_engine;

  localparam int MAX_DATA_W = 9;
  localparam int OS         = 16;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  sample_tick = 1'b0;
  logic [MAX_DATA_W-1:0] tx_data = '0;
  logic                  tx_valid = 1'b0;
  logic                  tx_ready;
  logic [3:0]            cfg_data_bits = 4'd8;
  logic                  cfg_parity_en = 1'b0;
  logic                  cfg_parity_odd = 1'b0;
  logic                  cfg_two_stop = 1'b0;
  logic                  TX;
  logic                  tx_busy;
  logic                  tx_done;
`ifdef UART_TX_BREAK_EN
  logic                  break_req = 1'b0;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  uart_tx_frame_engine #(.MAX_DATA_W(MAX_DATA_W), .OVERSAMPLE(OS), .CNT_W(6)) dut (
    .the_new_generated_clock(clk),
    .reset                  (reset),
    .sample_tick            (sample_tick),
    .tx_data                (tx_data),
    .tx_valid               (tx_valid),
    .tx_ready               (tx_ready),
    .cfg_data_bits          (cfg_data_bits),
    .cfg_parity_en          (cfg_parity_en),
    .cfg_parity_odd         (cfg_parity_odd),
    .cfg_two_stop           (cfg_two_stop),
`ifdef UART_TX_BREAK_EN
    .break_req              (break_req),
`endif
    .TX                     (TX),
    .tx_busy                (tx_busy),
    .tx_done                (tx_done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offers one character and follows the line tick by tick; the expected line level is the
  // frame's bit list indexed by (ticks since acceptance / OS). Observed vector is {TX,busy,done,ready}.
  task automatic send_frame(input logic [MAX_DATA_W-1:0] d, input logic [3:0] nb_cfg,
                            input logic pen, input logic podd, input logic two,
                            input int tick_pct, input bit keep_valid, input int abort_ticks,
                            input string tag, output int cycles);
    logic lvl[$];
    int   nb, ticks, total, n;
    logic p;
    logic [3:0] got, expv;
    bit   done_seen;
    nb = (nb_cfg < 4'd5) ? 5 : (int'(nb_cfg) > MAX_DATA_W) ? MAX_DATA_W : int'(nb_cfg);
    lvl.push_back(1'b0);
    p = podd;
    for (int i = 0; i < nb; i++) begin
      lvl.push_back(d[i]);
      p = p ^ d[i];
    end
    if (pen) lvl.push_back(p);
    lvl.push_back(1'b1);
    if (two) lvl.push_back(1'b1);
    total     = lvl.size() * OS;
    cycles    = -1;
    done_seen = 1'b0;

    n = 0;
    while (tx_ready !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    vectors++;
    if (tx_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s ready_wait: tx_ready=%b, required 1", tag, tx_ready);
    end

    tx_data        = d;
    cfg_data_bits  = nb_cfg;
    cfg_parity_en  = pen;
    cfg_parity_odd = podd;
    cfg_two_stop   = two;
    tx_valid       = 1'b1;
    sample_tick    = (int'($urandom_range(0, 99)) < tick_pct);
    step();
    tx_valid       = keep_valid;
    tx_data        = MAX_DATA_W'($urandom);
    cfg_data_bits  = 4'($urandom);
    cfg_parity_en  = 1'($urandom);
    cfg_parity_odd = 1'($urandom);
    cfg_two_stop   = 1'($urandom);

    ticks = 0;
    for (int c = 0; c < 20000; c++) begin
      got  = {TX, tx_busy, tx_done, tx_ready};
      expv = (ticks == total) ? 4'b1011 : {lvl[ticks / OS], 3'b100};
      vectors++;
      if (got !== expv) begin
        miscompares++;
        $display("FAIL %s cycle %0d tick %0d: {TX,busy,done,ready}=%b, required %b",
                 tag, c, ticks, got, expv);
      end
      if (ticks == total) begin
        cycles    = c;
        done_seen = 1'b1;
        break;
      end
      if (abort_ticks > 0 && ticks >= abort_ticks) return;
      sample_tick = (int'($urandom_range(0, 99)) < tick_pct);
      step();
      if (sample_tick) ticks++;
    end
    if (!done_seen) begin
      vectors++;
      miscompares++;
      $display("FAIL %s timeout: tx_done not seen, ticks=%0d of %0d", tag, ticks, total);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    sample_tick = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if ({TX, tx_busy, tx_done, tx_ready} !== 4'b1000) begin
        miscompares++;
        $display("FAIL reset_hold: {TX,busy,done,ready}=%b, required 1000",
                 {TX, tx_busy, tx_done, tx_ready});
      end
    end
    reset = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      vectors++;
      if ({TX, tx_busy, tx_done, tx_ready} !== 4'b1001) begin
        miscompares++;
        $display("FAIL idle_after_reset cycle %0d: {TX,busy,done,ready}=%b, required 1001",
                 i, {TX, tx_busy, tx_done, tx_ready});
      end
    end
  endtask

  task automatic test_basic_frame();
    int cyc;
    send_frame(9'h0A5, 4'd8, 1'b0, 1'b0, 1'b0, 100, 1'b0, 0, "frame_0a5", cyc);
    vectors++;
    if (cyc != 160) begin
      miscompares++;
      $display("FAIL frame_0a5_done_latency: %0d cycles, required 160", cyc);
    end
  endtask

  task automatic test_max_frame();
    int cyc;
    send_frame(9'h1FF, 4'd9, 1'b1, 1'b1, 1'b1, 100, 1'b0, 0, "frame_1ff_odd_2stop", cyc);
    vectors++;
    if (cyc != 13 * OS) begin
      miscompares++;
      $display("FAIL frame_1ff_done_latency: %0d cycles, required %0d", cyc, 13 * OS);
    end
  endtask

  task automatic test_clamp();
    int cyc;
    send_frame(9'h00F, 4'd3, 1'b1, 1'b0, 1'b0, 100, 1'b0, 0, "clamp_low", cyc);
    send_frame(MAX_DATA_W'($urandom), 4'd12, 1'b1, 1'b0, 1'b0, 60, 1'b0, 0, "clamp_high", cyc);
    send_frame(9'h1E0, 4'd0, 1'b1, 1'b1, 1'b0, 100, 1'b0, 0, "clamp_zero", cyc);
  endtask

  task automatic test_back_to_back();
    int cyc;
    send_frame(MAX_DATA_W'($urandom), 4'd8, 1'b1, 1'b0, 1'b0, 100, 1'b1, 0, "b2b_first", cyc);
    vectors++;
    if ({tx_done, tx_ready, tx_valid} !== 3'b111) begin
      miscompares++;
      $display("FAIL b2b_handover: {done,ready,valid}=%b, required 111",
               {tx_done, tx_ready, tx_valid});
    end
    send_frame(MAX_DATA_W'($urandom), 4'd7, 1'b0, 1'b0, 1'b1, 100, 1'b0, 0, "b2b_second", cyc);
    send_frame(MAX_DATA_W'($urandom), 4'd6, 1'b1, 1'b1, 1'b0, 50, 1'b1, 0, "b2b_third", cyc);
    send_frame(MAX_DATA_W'($urandom), 4'd9, 1'b0, 1'b0, 1'b0, 50, 1'b0, 0, "b2b_fourth", cyc);
  endtask

  task automatic test_reset_mid_frame();
    int cyc;
    send_frame(MAX_DATA_W'($urandom), 4'd8, 1'b1, 1'b0, 1'b1, 100, 1'b0, 4 * OS + 5,
               "abort_frame", cyc);
    reset = 1'b1;
    sample_tick = 1'b1;
    step();
    vectors++;
    if ({TX, tx_busy, tx_done, tx_ready} !== 4'b1000) begin
      miscompares++;
      $display("FAIL abort_reset: {TX,busy,done,ready}=%b, required 1000",
               {TX, tx_busy, tx_done, tx_ready});
    end
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      vectors++;
      if ({TX, tx_busy, tx_done, tx_ready} !== 4'b1001) begin
        miscompares++;
        $display("FAIL abort_recover cycle %0d: {TX,busy,done,ready}=%b, required 1001",
                 i, {TX, tx_busy, tx_done, tx_ready});
      end
    end
  endtask

  task automatic test_random_frames();
    int cyc;
    for (int k = 0; k < 20; k++) begin
      send_frame(MAX_DATA_W'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), int'($urandom_range(25, 100)), 1'($urandom), 0, "random", cyc);
    end
    tx_valid = 1'b0;
  endtask

`ifdef UART_TX_BREAK_EN
  task automatic test_break();
    sample_tick = 1'b1;
    break_req   = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      vectors++;
      if ({TX, tx_ready} !== 2'b00) begin
        miscompares++;
        $display("FAIL break_low cycle %0d: {TX,ready}=%b, required 00", i, {TX, tx_ready});
      end
    end
    break_req = 1'b0;
    for (int i = 0; i < OS; i++) begin
      step();
      vectors++;
      if ({TX, tx_ready} !== 2'b10) begin
        miscompares++;
        $display("FAIL break_hold cycle %0d: {TX,ready}=%b, required 10", i, {TX, tx_ready});
      end
    end
    step();
    vectors++;
    if ({TX, tx_ready} !== 2'b11) begin
      miscompares++;
      $display("FAIL break_release: {TX,ready}=%b, required 11", {TX, tx_ready});
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_frame();
    test_max_frame();
    test_clamp();
    test_back_to_back();
    test_reset_mid_frame();
    test_random_frames();
`ifdef UART_TX_BREAK_EN
    test_break();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
